ins_fetcher: RTL and testbench
==============================

# ins_fetcher

Instruction-fetch stage that sits directly upstream of the branch predictor. It fetches 32-bit instructions from the memory port and pre-decodes branches, jumps and JALR. For every conditional branch it runs the ask/answer handshake with the predictor. Fetched instructions, tagged with their prediction, go into a small FIFO that feeds decode. On the predictor's `if_flush` it redirects the PC and drops all speculative state.

## Interface
- `IQ_DEPTH`, 4, instruction-queue entries (power of two, ≥2)
- `RESET_PC`, 32'h0, PC loaded at reset
- `clk`  in  1  clock, all state updates on posedge
- `rst`  in  1  synchronous active-low reset (0 = reset), sampled on posedge `clk`
- `rdy`  in  1  global enable; when 0, all state holds
- `mem_req`  out  1  fetch request; held until `mem_valid`
- `mem_addr`  out  32  fetch address, stable while `mem_req`=1
- `mem_valid`  in  1  one-cycle pulse, `mem_data` valid
- `mem_data`  in  32  fetched instruction word
- `ask_predictor`  out  1  one-cycle query pulse for a conditional branch
- `now_ins_addr`  out  32  PC of queried branch
- `jump_addr_from_if`  out  32  branch PC + B-immediate
- `next_addr_from_if`  out  32  branch PC + 4
- `jump`  in  1  predictor decision, valid with `predictor_sgn_rdy`
- `predictor_sgn_rdy`  in  1  predictor answer strobe
- `predictor_full`  in  1  predictor cannot accept a query
- `if_flush`  in  1  mispredict redirect
- `addr_to_if`  in  32  redirect target, valid with `if_flush`
- `jalr_done`  in  1  JALR resolved downstream
- `jalr_target`  in  32  resolved JALR target
- `ins_valid`  out  1  queue head valid
- `ins`  out  32  head instruction
- `ins_pc`  out  32  head PC
- `ins_pred_jump`  out  1  head predicted taken
- `ins_accept`  in  1  decode takes head this cycle (ignored if `ins_valid`=0)

## Operation
- **States.**
  - S_FETCH: idle or request outstanding.
  - S_PFULL: branch held because `predictor_full`=1.
  - S_PRED: waiting for the predictor answer.
  - S_JALR: waiting for `jalr_done`.
- **S_FETCH issue.** Raise `mem_req` with `mem_addr`=pc only when queue count < IQ_DEPTH. Once raised, it stays high until `mem_valid`.
- **On `mem_valid`.** Decode opcode `mem_data[6:0]`:
  - 7'b1100011 (branch): if `predictor_full`, latch the word and go to S_PFULL. Otherwise pulse `ask_predictor` for exactly one cycle, drive the three address outputs, and go to S_PRED.
  - 7'b1101111 (JAL): handling depends on the configuration macro.
  - 7'b1100111 (JALR): enqueue with pred=0 and go to S_JALR.
  - Anything else: enqueue with pred=0, pc←pc+4, stay in S_FETCH.
- **S_PFULL.** Once `predictor_full`=0, pulse `ask_predictor` and go to S_PRED.
- **S_PRED.** On `predictor_sgn_rdy`, enqueue the branch with pred=`jump`. Set pc←`jump` ? pc+immB : pc+4, then return to S_FETCH.
- **S_JALR.** On `jalr_done`, pc←`jalr_target` and go to S_FETCH.
- **Immediates.** Sign-extended; all address sums are 32-bit modulo 2^32 (wrap, no overflow flag).
- **Queue.** Circular buffer with head/tail of log2(IQ_DEPTH) bits and a count of log2(IQ_DEPTH)+1 bits.
  - Enqueue and dequeue in the same cycle leave count unchanged.
  - `ins_valid` = (count≠0). `ins`/`ins_pc`/`ins_pred_jump` show the head entry.
- **Flush.** `if_flush`=1 has priority over every other event in that cycle:
  - queue emptied; pc←`addr_to_if`; state←S_FETCH; pending JALR and predictor waits abandoned.
  - If `mem_req` is outstanding, set `discard`. The request completes normally, its `mem_valid` is dropped without decode or enqueue, then `discard` clears and fetch restarts at the new pc.
- **Reset.** `rst`=0: pc←RESET_PC, state S_FETCH, count/head/tail←0, discard←0.
- **Stall.** `rdy`=0 freezes all state.

## Timing
- **Reset values.** `mem_req`=0, `mem_addr`=RESET_PC, `ask_predictor`=0, address outputs=0, `ins_valid`=0, `ins`=0, `ins_pc`=0, `ins_pred_jump`=0.
- **Non-branch path.** `mem_valid` at cycle T gives an enqueue visible at T+1 and a new `mem_req` at T+1 if space remains.
- **Branch path.** `mem_valid` at T gives `ask_predictor` at T+1. `predictor_sgn_rdy` at T+2 (earliest) gives the enqueue and new pc at T+3.
- **Flush timing.** `if_flush` at T gives `mem_req` with `addr_to_if` at T+1 if nothing is outstanding.
- **Full queue.** With queue full, `mem_req` stays 0 until an `ins_accept` drops count.
- **Reset mid-transaction.** Reset while a request is outstanding: the memory side is also reset; no discard is carried over.

## Configuration
- `IF_STATIC_JAL_EN` defined: JAL is enqueued with pred=1 and pc←pc+immJ in the same update; no stall.
- `IF_STATIC_JAL_EN` undefined: JAL is handled exactly like JALR (enqueue with pred=0, wait in S_JALR for `jalr_done`).

## Test plan
- **Reset and sequential fetch.** Reset with RESET_PC=0, feed 3 ADDI words → `mem_addr` 0,4,8; queue holds 3 entries with pred=0.
- **Predicted-taken branch.** BEQ at 0x10 with immB=+0x20, `jump`=1 → `ask_predictor` pulse with `now_ins_addr`=0x10, `jump_addr_from_if`=0x30, `next_addr_from_if`=0x14; next fetch at 0x30; entry pred=1.
- **Predictor full.** BNE with `predictor_full`=1 for 5 cycles → no `ask_predictor` until full drops; exactly one pulse afterwards.
- **Flush during outstanding fetch.** `if_flush` with `addr_to_if`=0x200 while fetch of 0x8 is outstanding → the 0x8 response is discarded, queue empty, next `mem_addr`=0x200.
- **Queue backpressure.** IQ_DEPTH=4 with `ins_accept`=0 → after 4 enqueues `mem_req` stays low; one accept → one new request.
- **JAL under both builds.** JAL at 0x40 with immJ=−0x40 → with `IF_STATIC_JAL_EN` next fetch at 0x0; without it, fetch stalls until `jalr_done` with target 0x0.

Source files
------------

// File: rtl/ins_fetcher_if.sv
// Fetch-stage bus bundle: memory port, predictor handshake, redirects and decode queue head.
interface ins_fetcher_if;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_valid;
   logic [31:0] mem_data;
   logic        ask_predictor;
   logic [31:0] now_ins_addr;
   logic [31:0] jump_addr_from_if;
   logic [31:0] next_addr_from_if;
   logic        jump;
   logic        predictor_sgn_rdy;
   logic        predictor_full;
   logic        if_flush;
   logic [31:0] addr_to_if;
   logic        jalr_done;
   logic [31:0] jalr_target;
   logic        ins_valid;
   logic [31:0] ins;
   logic [31:0] ins_pc;
   logic        ins_pred_jump;
   logic        ins_accept;

   modport master (
      output mem_req, mem_addr, ask_predictor, now_ins_addr, jump_addr_from_if,
             next_addr_from_if, ins_valid, ins, ins_pc, ins_pred_jump,
      input  mem_valid, mem_data, jump, predictor_sgn_rdy, predictor_full, if_flush,
             addr_to_if, jalr_done, jalr_target, ins_accept
   );

   modport slave (
      input  mem_req, mem_addr, ask_predictor, now_ins_addr, jump_addr_from_if,
             next_addr_from_if, ins_valid, ins, ins_pc, ins_pred_jump,
      output mem_valid, mem_data, jump, predictor_sgn_rdy, predictor_full, if_flush,
             addr_to_if, jalr_done, jalr_target, ins_accept
   );
endinterface

// File: rtl/ins_fetcher.sv
// Instruction fetch with branch pre-decode, predictor handshake and decode queue.
// Optional IF_STATIC_JAL_EN: JAL is taken statically instead of waiting for jalr_done.
module ins_fetcher #(
   parameter int unsigned IQ_DEPTH = 4,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          rdy,
   ins_fetcher_if.master bus
);
   localparam int unsigned PTR_W = (IQ_DEPTH > 1) ? $clog2(IQ_DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [6:0]  OP_BRANCH = 7'b1100011;
   localparam logic [6:0]  OP_JAL    = 7'b1101111;
   localparam logic [6:0]  OP_JALR   = 7'b1100111;

   typedef enum logic [1:0] {S_FETCH, S_PFULL, S_PRED, S_JALR} state_t;

   state_t           r_state, w_state_next;
   logic [31:0]      r_pc, r_br_ins, r_mem_addr;
   logic             r_discard, r_mem_req, r_ask;
   logic [31:0]      r_now_addr, r_jump_addr, r_next_addr;
   logic [31:0]      r_q_ins [IQ_DEPTH];
   logic [31:0]      r_q_pc  [IQ_DEPTH];
   logic             r_q_pred[IQ_DEPTH];
   logic [PTR_W-1:0] r_head, r_tail;
   logic [CNT_W-1:0] r_count;

   logic             w_resp, w_deq, w_enq, w_enq_pred, w_ask_next, w_discard_next, w_latch_br;
   logic             w_mem_req_next;
   logic [6:0]       w_op;
   logic [31:0]      w_br_word, w_imm_b, w_br_target, w_pc_plus4, w_pc_next, w_enq_ins;
   logic [31:0]      w_mem_addr_next;
   logic [PTR_W-1:0] w_head_next, w_tail_next;
   logic [CNT_W-1:0] w_count_next;

   assign w_resp      = bus.mem_valid && r_mem_req;
   assign w_deq       = bus.ins_accept && (r_count != '0);
   assign w_op        = bus.mem_data[6:0];
   assign w_br_word   = (r_state == S_FETCH) ? bus.mem_data : r_br_ins;
   assign w_imm_b     = {{20{w_br_word[31]}}, w_br_word[7], w_br_word[30:25], w_br_word[11:8], 1'b0};
   assign w_br_target = r_pc + w_imm_b;
   assign w_pc_plus4  = r_pc + 32'd4;

`ifdef IF_STATIC_JAL_EN
   logic [31:0] w_imm_j;
   assign w_imm_j = {{12{bus.mem_data[31]}}, bus.mem_data[19:12], bus.mem_data[20],
                     bus.mem_data[30:21], 1'b0};
`endif

   always_ff @(posedge clk) begin
      if (!rst)     r_state <= S_FETCH;
      else if (rdy) r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      if (bus.if_flush) begin
         w_state_next = S_FETCH;
      end else begin
         case (r_state)
            S_FETCH: begin
               if (w_resp && !r_discard) begin
                  case (w_op)
                     OP_BRANCH: w_state_next = bus.predictor_full ? S_PFULL : S_PRED;
`ifdef IF_STATIC_JAL_EN
                     OP_JAL:    w_state_next = S_FETCH;
`else
                     OP_JAL:    w_state_next = S_JALR;
`endif
                     OP_JALR:   w_state_next = S_JALR;
                     default:   w_state_next = S_FETCH;
                  endcase
               end
            end
            S_PFULL: if (!bus.predictor_full)   w_state_next = S_PRED;
            S_PRED:  if (bus.predictor_sgn_rdy) w_state_next = S_FETCH;
            S_JALR:  if (bus.jalr_done)         w_state_next = S_FETCH;
            default: w_state_next = S_FETCH;
         endcase
      end
   end

   // Per-state datapath actions; flush overrides everything in its cycle.
   always_comb begin
      w_pc_next      = r_pc;
      w_enq          = 1'b0;
      w_enq_ins      = bus.mem_data;
      w_enq_pred     = 1'b0;
      w_ask_next     = 1'b0;
      w_discard_next = r_discard;
      w_latch_br     = 1'b0;
      if (bus.if_flush) begin
         w_pc_next      = bus.addr_to_if;
         w_discard_next = r_mem_req && !bus.mem_valid;
      end else begin
         case (r_state)
            S_FETCH: begin
               if (w_resp && r_discard) begin
                  w_discard_next = 1'b0;
               end else if (w_resp) begin
                  case (w_op)
                     OP_BRANCH: begin
                        w_latch_br = 1'b1;
                        w_ask_next = !bus.predictor_full;
                     end
                     OP_JAL: begin
                        w_enq = 1'b1;
`ifdef IF_STATIC_JAL_EN
                        w_enq_pred = 1'b1;
                        w_pc_next  = r_pc + w_imm_j;
`endif
                     end
                     OP_JALR: w_enq = 1'b1;
                     default: begin
                        w_enq     = 1'b1;
                        w_pc_next = w_pc_plus4;
                     end
                  endcase
               end
            end
            S_PFULL: w_ask_next = !bus.predictor_full;
            S_PRED: begin
               if (bus.predictor_sgn_rdy) begin
                  w_enq      = 1'b1;
                  w_enq_ins  = r_br_ins;
                  w_enq_pred = bus.jump;
                  w_pc_next  = bus.jump ? w_br_target : w_pc_plus4;
               end
            end
            S_JALR: if (bus.jalr_done) w_pc_next = bus.jalr_target;
            default: ;
         endcase
      end
   end

   always_comb begin
      w_head_next  = r_head + PTR_W'(w_deq);
      w_tail_next  = r_tail + PTR_W'(w_enq);
      w_count_next = r_count + CNT_W'(w_enq) - CNT_W'(w_deq);
      if (bus.if_flush) begin
         w_head_next  = '0;
         w_tail_next  = '0;
         w_count_next = '0;
      end
   end

   // A request stays up with a frozen address until its response returns.
   always_comb begin
      w_mem_req_next  = 1'b0;
      w_mem_addr_next = r_mem_addr;
      if (r_mem_req && !bus.mem_valid) begin
         w_mem_req_next = 1'b1;
      end else if (w_state_next == S_FETCH && !w_discard_next &&
                   w_count_next < CNT_W'(IQ_DEPTH)) begin
         w_mem_req_next  = 1'b1;
         w_mem_addr_next = w_pc_next;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_pc        <= RESET_PC;
         r_br_ins    <= '0;
         r_discard   <= 1'b0;
         r_mem_req   <= 1'b0;
         r_mem_addr  <= RESET_PC;
         r_ask       <= 1'b0;
         r_now_addr  <= '0;
         r_jump_addr <= '0;
         r_next_addr <= '0;
         r_head      <= '0;
         r_tail      <= '0;
         r_count     <= '0;
         for (int i = 0; i < int'(IQ_DEPTH); i++) begin
            r_q_ins[i]  <= '0;
            r_q_pc[i]   <= '0;
            r_q_pred[i] <= 1'b0;
         end
      end else if (rdy) begin
         r_pc       <= w_pc_next;
         r_discard  <= w_discard_next;
         r_mem_req  <= w_mem_req_next;
         r_mem_addr <= w_mem_addr_next;
         r_ask      <= w_ask_next;
         if (w_ask_next) begin
            r_now_addr  <= r_pc;
            r_jump_addr <= w_br_target;
            r_next_addr <= w_pc_plus4;
         end
         if (w_latch_br) r_br_ins <= bus.mem_data;
         if (w_enq) begin
            r_q_ins[r_tail]  <= w_enq_ins;
            r_q_pc[r_tail]   <= r_pc;
            r_q_pred[r_tail] <= w_enq_pred;
         end
         r_head  <= w_head_next;
         r_tail  <= w_tail_next;
         r_count <= w_count_next;
      end
   end

   assign bus.mem_req           = r_mem_req;
   assign bus.mem_addr          = r_mem_addr;
   assign bus.ask_predictor     = r_ask;
   assign bus.now_ins_addr      = r_now_addr;
   assign bus.jump_addr_from_if = r_jump_addr;
   assign bus.next_addr_from_if = r_next_addr;
   assign bus.ins_valid         = (r_count != '0);
   assign bus.ins               = r_q_ins[r_head];
   assign bus.ins_pc            = r_q_pc[r_head];
   assign bus.ins_pred_jump     = r_q_pred[r_head];
endmodule

// File: tb/tb_ins_fetcher.sv
// Scoreboard bench for ins_fetcher: expected queue entries are pushed as words are served.
module tb_ins_fetcher;
   logic clk = 1'b0;
   logic rst;
   logic rdy;
   int   checks = 0;
   int   errors = 0;

   typedef struct {
      logic [31:0] ins;
      logic [31:0] pc;
      logic        pred;
   } exp_t;
   exp_t sb[$];

   localparam logic [31:0] ADDI = 32'h00100093;

   ins_fetcher_if bus();

   ins_fetcher #(.IQ_DEPTH(4), .RESET_PC(32'h0)) dut (
      .clk (clk),
      .rst (rst),
      .rdy (rdy),
      .bus (bus.master)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [2:0] f3);
      return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
   endfunction

   function automatic logic [31:0] enc_j(input logic [20:0] imm);
      return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.mem_valid         = 1'b0;
      bus.mem_data          = '0;
      bus.jump              = 1'b0;
      bus.predictor_sgn_rdy = 1'b0;
      bus.predictor_full    = 1'b0;
      bus.if_flush          = 1'b0;
      bus.addr_to_if        = '0;
      bus.jalr_done         = 1'b0;
      bus.jalr_target       = '0;
      bus.ins_accept        = 1'b0;
   endtask

   task automatic do_reset();
      clear_inputs();
      sb.delete();
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
   endtask

   // Leave reset with a flush so the first fetch starts at pc.
   task automatic do_reset_to(input logic [31:0] pc);
      clear_inputs();
      sb.delete();
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      bus.if_flush   = 1'b1;
      bus.addr_to_if = pc;
      tick();
      bus.if_flush = 1'b0;
   endtask

   task automatic wait_req(input string name, input logic [31:0] exp_addr);
      int n = 0;
      while (!bus.mem_req && n < 20) begin
         tick();
         n++;
      end
      checks++;
      if (bus.mem_req !== 1'b1) begin
         errors++;
         $display("FAIL %s: no mem_req after %0d cycles, expected addr %h", name, n, exp_addr);
      end else if (bus.mem_addr !== exp_addr) begin
         errors++;
         $display("FAIL %s: mem_addr got %h expected %h", name, bus.mem_addr, exp_addr);
      end
   endtask

   task automatic respond(input logic [31:0] word);
      bus.mem_data  = word;
      bus.mem_valid = 1'b1;
      tick();
      bus.mem_valid = 1'b0;
      bus.mem_data  = '0;
   endtask

   task automatic drain(input string name);
      int   n = 0;
      exp_t e;
      while (sb.size() > 0 && n < 40) begin
         if (bus.ins_valid === 1'b1) begin
            e = sb.pop_front();
            checks++;
            if (bus.ins !== e.ins || bus.ins_pc !== e.pc || bus.ins_pred_jump !== e.pred) begin
               errors++;
               $display("FAIL %s head: got ins=%h pc=%h pred=%b expected ins=%h pc=%h pred=%b",
                        name, bus.ins, bus.ins_pc, bus.ins_pred_jump, e.ins, e.pc, e.pred);
            end
            bus.ins_accept = 1'b1;
         end else begin
            bus.ins_accept = 1'b0;
         end
         tick();
         n++;
      end
      bus.ins_accept = 1'b0;
      checks++;
      if (sb.size() != 0 || bus.ins_valid !== 1'b0) begin
         errors++;
         $display("FAIL %s end: %0d entries still expected, ins_valid=%b expected 0",
                  name, sb.size(), bus.ins_valid);
      end
   endtask

   task automatic test_reset();
      clear_inputs();
      rst = 1'b0;
      tick();
      tick();
      checks++;
      if (bus.mem_req !== 1'b0 || bus.mem_addr !== 32'h0 || bus.ask_predictor !== 1'b0) begin
         errors++;
         $display("FAIL reset_mem: req=%b addr=%h ask=%b expected 0/0/0",
                  bus.mem_req, bus.mem_addr, bus.ask_predictor);
      end
      checks++;
      if (bus.now_ins_addr !== 32'h0 || bus.jump_addr_from_if !== 32'h0 ||
          bus.next_addr_from_if !== 32'h0) begin
         errors++;
         $display("FAIL reset_pred_addr: now=%h jump=%h next=%h expected 0",
                  bus.now_ins_addr, bus.jump_addr_from_if, bus.next_addr_from_if);
      end
      checks++;
      if (bus.ins_valid !== 1'b0 || bus.ins !== 32'h0 || bus.ins_pc !== 32'h0 ||
          bus.ins_pred_jump !== 1'b0) begin
         errors++;
         $display("FAIL reset_queue: valid=%b ins=%h pc=%h pred=%b expected 0",
                  bus.ins_valid, bus.ins, bus.ins_pc, bus.ins_pred_jump);
      end
   endtask

   task automatic test_sequential();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         wait_req("seq_addr", 32'(i * 4));
         respond(ADDI);
         sb.push_back('{ins: ADDI, pc: 32'(i * 4), pred: 1'b0});
         checks++;
         if (bus.ins_valid !== 1'b1 || bus.mem_req !== 1'b1) begin
            errors++;
            $display("FAIL seq_next_cycle: ins_valid=%b mem_req=%b expected 1/1",
                     bus.ins_valid, bus.mem_req);
         end
      end
      drain("seq");
   endtask

   task automatic test_branch_taken();
      logic [31:0] w;
      w = enc_b(13'h020, 3'b000);
      do_reset_to(32'h10);
      wait_req("br_fetch", 32'h10);
      respond(w);
      sb.push_back('{ins: w, pc: 32'h10, pred: 1'b1});
      checks++;
      if (bus.ask_predictor !== 1'b1 || bus.now_ins_addr !== 32'h10 ||
          bus.jump_addr_from_if !== 32'h30 || bus.next_addr_from_if !== 32'h14) begin
         errors++;
         $display("FAIL br_ask: ask=%b now=%h jump=%h next=%h expected 1/10/30/14",
                  bus.ask_predictor, bus.now_ins_addr, bus.jump_addr_from_if,
                  bus.next_addr_from_if);
      end
      tick();
      checks++;
      if (bus.ask_predictor !== 1'b0 || bus.mem_req !== 1'b0) begin
         errors++;
         $display("FAIL br_pulse: ask=%b mem_req=%b expected 0/0", bus.ask_predictor, bus.mem_req);
      end
      bus.jump              = 1'b1;
      bus.predictor_sgn_rdy = 1'b1;
      tick();
      bus.jump              = 1'b0;
      bus.predictor_sgn_rdy = 1'b0;
      checks++;
      if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h30) begin
         errors++;
         $display("FAIL br_target: req=%b addr=%h expected 1/30", bus.mem_req, bus.mem_addr);
      end
      drain("br");
   endtask

   task automatic test_predictor_full();
      logic [31:0] w;
      int          pulses = 0;
      w = enc_b(13'h008, 3'b001);
      do_reset_to(32'h20);
      bus.predictor_full = 1'b1;
      wait_req("pfull_fetch", 32'h20);
      respond(w);
      sb.push_back('{ins: w, pc: 32'h20, pred: 1'b0});
      for (int i = 0; i < 5; i++) begin
         if (bus.ask_predictor === 1'b1) pulses++;
         tick();
      end
      checks++;
      if (pulses != 0) begin
         errors++;
         $display("FAIL pfull_hold: %0d ask pulses while full, expected 0", pulses);
      end
      bus.predictor_full = 1'b0;
      tick();
      checks++;
      if (bus.ask_predictor !== 1'b1 || bus.now_ins_addr !== 32'h20 ||
          bus.jump_addr_from_if !== 32'h28 || bus.next_addr_from_if !== 32'h24) begin
         errors++;
         $display("FAIL pfull_ask: ask=%b now=%h jump=%h next=%h expected 1/20/28/24",
                  bus.ask_predictor, bus.now_ins_addr, bus.jump_addr_from_if,
                  bus.next_addr_from_if);
      end
      for (int i = 0; i < 4; i++) begin
         if (bus.ask_predictor === 1'b1) pulses++;
         tick();
      end
      checks++;
      if (pulses != 1) begin
         errors++;
         $display("FAIL pfull_once: %0d ask pulses, expected 1", pulses);
      end
      bus.predictor_sgn_rdy = 1'b1;
      tick();
      bus.predictor_sgn_rdy = 1'b0;
      wait_req("pfull_fallthrough", 32'h24);
      drain("pfull");
   endtask

   task automatic test_flush();
      do_reset();
      for (int i = 0; i < 2; i++) begin
         wait_req("flush_pre", 32'(i * 4));
         respond(ADDI);
         sb.push_back('{ins: ADDI, pc: 32'(i * 4), pred: 1'b0});
      end
      wait_req("flush_outstanding", 32'h8);
      bus.if_flush   = 1'b1;
      bus.addr_to_if = 32'h200;
      tick();
      bus.if_flush = 1'b0;
      sb.delete();
      checks++;
      if (bus.ins_valid !== 1'b0 || bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h8) begin
         errors++;
         $display("FAIL flush_state: valid=%b req=%b addr=%h expected 0/1/8",
                  bus.ins_valid, bus.mem_req, bus.mem_addr);
      end
      tick();
      respond(ADDI);
      checks++;
      if (bus.ins_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_discard: ins_valid=%b expected 0", bus.ins_valid);
      end
      wait_req("flush_redirect", 32'h200);
      respond(ADDI);
      sb.push_back('{ins: ADDI, pc: 32'h200, pred: 1'b0});
      drain("flush");
   endtask

   task automatic test_backpressure();
      int   busy = 0;
      exp_t e;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         wait_req("bp_fill", 32'(i * 4));
         respond(ADDI);
         sb.push_back('{ins: ADDI, pc: 32'(i * 4), pred: 1'b0});
      end
      for (int i = 0; i < 6; i++) begin
         if (bus.mem_req !== 1'b0) busy++;
         tick();
      end
      checks++;
      if (busy != 0) begin
         errors++;
         $display("FAIL bp_full: mem_req high %0d cycles with full queue, expected 0", busy);
      end
      e = sb.pop_front();
      checks++;
      if (bus.ins !== e.ins || bus.ins_pc !== e.pc || bus.ins_pred_jump !== e.pred) begin
         errors++;
         $display("FAIL bp_head: got ins=%h pc=%h expected ins=%h pc=%h",
                  bus.ins, bus.ins_pc, e.ins, e.pc);
      end
      bus.ins_accept = 1'b1;
      tick();
      bus.ins_accept = 1'b0;
      checks++;
      if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h10) begin
         errors++;
         $display("FAIL bp_resume: req=%b addr=%h expected 1/10", bus.mem_req, bus.mem_addr);
      end
      respond(ADDI);
      sb.push_back('{ins: ADDI, pc: 32'h10, pred: 1'b0});
      checks++;
      if (bus.mem_req !== 1'b0) begin
         errors++;
         $display("FAIL bp_single: mem_req=%b after refilling, expected 0", bus.mem_req);
      end
      drain("bp");
   endtask

   task automatic test_jal();
      logic [31:0] w;
      w = enc_j(21'h1FFFC0);
      do_reset_to(32'h40);
      wait_req("jal_fetch", 32'h40);
      respond(w);
`ifdef IF_STATIC_JAL_EN
      sb.push_back('{ins: w, pc: 32'h40, pred: 1'b1});
      checks++;
      if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0) begin
         errors++;
         $display("FAIL jal_static: req=%b addr=%h expected 1/0", bus.mem_req, bus.mem_addr);
      end
`else
      sb.push_back('{ins: w, pc: 32'h40, pred: 1'b0});
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (bus.mem_req !== 1'b0) begin
            errors++;
            $display("FAIL jal_stall: mem_req=%b while waiting for jalr_done, expected 0",
                     bus.mem_req);
         end
         tick();
      end
      bus.jalr_done   = 1'b1;
      bus.jalr_target = 32'h0;
      tick();
      bus.jalr_done = 1'b0;
      checks++;
      if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0) begin
         errors++;
         $display("FAIL jal_resolve: req=%b addr=%h expected 1/0", bus.mem_req, bus.mem_addr);
      end
`endif
      drain("jal");
   endtask

   initial begin
      rdy = 1'b1;
      rst = 1'b0;
      clear_inputs();
      test_reset();
      test_sequential();
      test_branch_taken();
      test_predictor_full();
      test_flush();
      test_backpressure();
      test_jal();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
